// File: rtl/phased_clk_pkg.sv
// Shared types and defaults for the phased clock generator.
package phased_clk_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int NCH_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/phase_chan.sv
// One phased output: modular distance from the shared counter, registered level and rising-edge tick.
module phase_chan
  import phased_clk_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [DIV_W:0]   i_cnt,
  input  logic [DIV_W:0]   i_per,
  input  logic [DIV_W-1:0] i_half,
  input  logic [DIV_W-1:0] i_phase,
  output logic             o_clk_out,
  output logic             o_tick
);

  logic [DIV_W:0] w_phase;
  logic [DIV_W:0] w_dist;
  logic           w_level;
  logic           r_clk_out;
  logic           r_tick;

  // (cnt - phase) mod P; the else-branch adds (P - phase) first so the sum never exceeds P
  assign w_phase = {1'b0, i_phase};
  assign w_dist  = (i_cnt >= w_phase) ? (i_cnt - w_phase) : (i_cnt + (i_per - w_phase));
  assign w_level = (w_dist < {1'b0, i_half});

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_clk_out <= w_level;
      r_tick    <= w_level & ~r_clk_out;
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;

endmodule

// File: rtl/phased_clk_gen.sv
// Phase-aligned square-wave generator: config latch, IDLE/ARM/RUN control and one shared period counter.
module phased_clk_gen
  import phased_clk_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DIV_W-1:0]     cfg_half,
  input  logic [NCH*DIV_W-1:0] cfg_phase,
  input  logic                 start,
  input  logic                 stop,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic                 running,
  output logic                 cfg_err
);

  localparam logic [DIV_W-1:0] HALF_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t                 r_state;
  logic [DIV_W-1:0]       r_half;
  logic [NCH*DIV_W-1:0]   r_phase;
  logic [DIV_W:0]         r_cnt;
  logic                   r_running;
  logic                   r_cfg_err;

  logic [DIV_W:0]         w_per;
  logic [DIV_W-1:0]       w_half_new;
  logic [DIV_W:0]         w_per_new;
  logic [NCH*DIV_W-1:0]   w_phase_new;
  logic                   w_phase_bad;
  logic                   w_chan_en;

  // A phase at or beyond the period is pinned to the last cycle of the period
  function automatic logic [DIV_W-1:0] sat_phase(input logic [DIV_W-1:0] ph,
                                                  input logic [DIV_W:0]   per);
    if ({1'b0, ph} >= per) return per[DIV_W-1:0] - 1'b1;
    return ph;
  endfunction

  assign w_per      = {r_half, 1'b0};
  assign w_half_new = (cfg_half == '0) ? HALF_ONE : cfg_half;
  assign w_per_new  = {w_half_new, 1'b0};

  always_comb begin
    w_phase_new = '0;
    w_phase_bad = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      w_phase_new[k*DIV_W +: DIV_W] = sat_phase(cfg_phase[k*DIV_W +: DIV_W], w_per_new);
      if ({1'b0, cfg_phase[k*DIV_W +: DIV_W]} >= w_per_new) w_phase_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_half    <= HALF_ONE;
      r_phase   <= '0;
      r_running <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cfg_valid) begin
            r_half    <= w_half_new;
            r_phase   <= w_phase_new;
            r_cfg_err <= (cfg_half == '0) || w_phase_bad;
            r_state   <= ARM;
          end
        end
        ARM: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (start) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end else begin
            r_cnt <= (r_cnt == w_per - 1'b1) ? '0 : r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Channels drop to zero on the same edge that a stop leaves RUN
  assign w_chan_en = (r_state == RUN) && !stop;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    phase_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_en      (w_chan_en),
      .i_cnt     (r_cnt),
      .i_per     (w_per),
      .i_half    (r_half),
      .i_phase   (r_phase[k*DIV_W +: DIV_W]),
      .o_clk_out (clk_out[k]),
      .o_tick    (tick[k])
    );
  end

  assign cfg_ready = (r_state == IDLE);
  assign running   = r_running;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_phased_clk_gen.sv
// Directed bench for phased_clk_gen (NCH=4, DIV_W=8) with hand-derived waveforms.
module tb_phased_clk_gen;

  localparam int NCH   = 4;
  localparam int DIV_W = 8;

  logic                 clk;
  logic                 rst;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [DIV_W-1:0]     cfg_half;
  logic [NCH*DIV_W-1:0] cfg_phase;
  logic                 start;
  logic                 stop;
  logic [NCH-1:0]       clk_out;
  logic [NCH-1:0]       tick;
  logic                 running;
  logic                 cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] exp_clk3  [6];
  logic [3:0] exp_tick3 [6];
  logic [3:0] exp_clk2  [4];

  phased_clk_gen #(
    .NCH   (NCH),
    .DIV_W (DIV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_half  (cfg_half),
    .cfg_phase (cfg_phase),
    .start     (start),
    .stop      (stop),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] h, input logic [31:0] ph);
    cfg_valid = 1'b1;
    cfg_half  = h;
    cfg_phase = ph;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // H=3, phases {0,1,2,3}: c counts cycles since the first high of channel 0
  task automatic run_basic(input int c0, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk_val({tag, "_clk"},  32'(clk_out), 32'(exp_clk3[(c0 + i) % 6]));
      chk_val({tag, "_tick"}, 32'(tick),    32'(exp_tick3[(c0 + i) % 6]));
    end
  endtask

  initial begin
    exp_clk3  = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    exp_tick3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    exp_clk2  = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};

    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    cfg_phase = '0;
    start     = 1'b0;
    stop      = 1'b0;
    step();
    step();
    chk_val("rst_clk",     32'(clk_out), 32'h0);
    chk_val("rst_tick",    32'(tick),    32'h0);
    chk_val("rst_running", 32'(running), 32'h0);
    chk_val("rst_err",     32'(cfg_err), 32'h0);
    rst = 1'b0;
    chk_val("rst_ready",   32'(cfg_ready), 32'h1);

    // basic phases
    do_cfg(8'd3, {8'd3, 8'd2, 8'd1, 8'd0});
    chk_val("arm_ready",   32'(cfg_ready), 32'h0);
    chk_val("arm_running", 32'(running),   32'h0);
    do_start();
    chk_val("t1_running",  32'(running),   32'h1);
    chk_val("t1_clk",      32'(clk_out),   32'h0);
    run_basic(0, 12, "basic");

    // stop, start-in-IDLE ignored, restart with same config
    do_stop();
    chk_val("stop_clk",     32'(clk_out),   32'h0);
    chk_val("stop_tick",    32'(tick),      32'h0);
    chk_val("stop_running", 32'(running),   32'h0);
    chk_val("stop_ready",   32'(cfg_ready), 32'h1);
    do_start();
    chk_val("idle_start_running", 32'(running),   32'h0);
    chk_val("idle_start_ready",   32'(cfg_ready), 32'h1);
    do_cfg(8'd3, {8'd3, 8'd2, 8'd1, 8'd0});
    do_start();
    run_basic(0, 8, "restart");

    // config offered while running must be ignored
    cfg_valid = 1'b1;
    cfg_half  = 8'd1;
    cfg_phase = '0;
    chk_val("run_ready", 32'(cfg_ready), 32'h0);
    run_basic(8, 6, "runcfg");
    cfg_valid = 1'b0;
    run_basic(14, 4, "runcfg_after");
    do_stop();

    // start and stop together in ARM: stop wins
    do_cfg(8'd3, {8'd3, 8'd2, 8'd1, 8'd0});
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk_val("both_ready",   32'(cfg_ready), 32'h1);
    chk_val("both_running", 32'(running),   32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_val("both_clk", 32'(clk_out), 32'h0);
    end

    // H=0 -> stored as 1, every channel toggles each cycle
    do_cfg(8'd0, {8'd1, 8'd0, 8'd1, 8'd0});
    chk_val("h0_err", 32'(cfg_err), 32'h1);
    do_start();
    for (int i = 0; i < 6; i++) begin
      step();
      chk_val("h1_clk", 32'(clk_out), (i % 2 == 0) ? 32'h5 : 32'hA);
    end
    do_stop();

    // phase 9 with H=2 -> stored as 3, error stays set
    do_cfg(8'd2, {8'd2, 8'd1, 8'd0, 8'd9});
    chk_val("ph9_err", 32'(cfg_err), 32'h1);
    do_start();
    for (int i = 0; i < 8; i++) begin
      step();
      chk_val("ph9_clk", 32'(clk_out), 32'(exp_clk2[i % 4]));
    end
    do_stop();
    chk_val("ph9_err_kept", 32'(cfg_err), 32'h1);

    // fully in-range config clears the error
    do_cfg(8'd3, {8'd3, 8'd2, 8'd1, 8'd0});
    chk_val("clr_err", 32'(cfg_err), 32'h0);
    do_stop();

    // reset mid-run, H=5, ch3 phase 20 -> 9
    do_cfg(8'd5, {8'd20, 8'd2, 8'd1, 8'd0});
    chk_val("h5_err", 32'(cfg_err), 32'h1);
    do_start();
    step();
    chk_val("h5_c0_clk",  32'(clk_out), 32'h9);
    chk_val("h5_c0_tick", 32'(tick),    32'h9);
    step();
    step();
    step();
    chk_val("h5_c3_clk", 32'(clk_out), 32'hF);
    rst = 1'b1;
    step();
    chk_val("mid_rst_clk",     32'(clk_out),   32'h0);
    chk_val("mid_rst_tick",    32'(tick),      32'h0);
    chk_val("mid_rst_running", 32'(running),   32'h0);
    chk_val("mid_rst_err",     32'(cfg_err),   32'h0);
    chk_val("mid_rst_ready",   32'(cfg_ready), 32'h1);
    rst = 1'b0;
    step();
    chk_val("post_rst_clk", 32'(clk_out), 32'h0);

    // wrap-around: H=127, P=254, ch1 phase 253 leads ch0 by one cycle
    do_cfg(8'd127, {8'd0, 8'd0, 8'd253, 8'd0});
    chk_val("wrap_err", 32'(cfg_err), 32'h0);
    do_start();
    for (int c = 0; c < 509; c++) begin
      step();
      if (c == 125) chk_val("wrap125_clk", 32'(clk_out[1:0]), 32'h3);
      if (c == 126) chk_val("wrap126_clk", 32'(clk_out[1:0]), 32'h1);
      if (c == 127) chk_val("wrap127_clk", 32'(clk_out[1:0]), 32'h0);
      if (c == 252) chk_val("wrap252_clk", 32'(clk_out[1:0]), 32'h0);
      if (c == 253) begin
        chk_val("wrap253_clk",  32'(clk_out[1:0]), 32'h2);
        chk_val("wrap253_tick", 32'(tick[1:0]),    32'h2);
      end
      if (c == 254) begin
        chk_val("wrap254_clk",  32'(clk_out[1:0]), 32'h3);
        chk_val("wrap254_tick", 32'(tick[1:0]),    32'h1);
      end
      if (c == 380) chk_val("wrap380_clk",  32'(clk_out[1:0]), 32'h1);
      if (c == 507) chk_val("wrap507_tick", 32'(tick[1:0]),    32'h2);
    end
    do_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phased_clk_gen.md
PHASED_CLK_GEN -- requirements
Module: phased_clk_gen

Interface
REQ-001 Parameter NCH, default 4: number of phased output channels, range 1..16.
REQ-002 Parameter DIV_W, default 16: width of the half-period and phase fields.
REQ-003 Port clk  input  1  sole clock; every register is clocked on its rising edge.
REQ-004 Port rst  input  1  synchronous reset, active-high.
REQ-005 Port cfg_valid  input  1  configuration offered.
REQ-006 Port cfg_ready  output  1  configuration accepted when high together with cfg_valid.
REQ-007 Port cfg_half  input  DIV_W  half-period H, counted in clk cycles.
REQ-008 Port cfg_phase  input  NCH*DIV_W  per-channel phase offset; channel k occupies bits [k*DIV_W +: DIV_W].
REQ-009 Port start  input  1  single-cycle pulse that launches all channels together.
REQ-010 Port stop  input  1  single-cycle pulse that halts all channels.
REQ-011 Port clk_out  output  NCH  registered square waves with 50% duty cycle.
REQ-012 Port tick  output  NCH  one-cycle pulse on each rising edge of clk_out[k].
REQ-013 Port running  output  1  high while in RUN.
REQ-014 Port cfg_err  output  1  sticky flag set by an out-of-range configuration.

Function
REQ-015 The state machine SHALL have three states: IDLE, ARM and RUN.
REQ-016 cfg_ready SHALL be high only in IDLE; a handshake SHALL latch H and all phases, then move to ARM.
REQ-017 If H==0 is accepted, H SHALL be stored as 1 and cfg_err SHALL be set.
REQ-018 Period P SHALL equal 2*H, held in a (DIV_W+1)-bit counter.
REQ-019 Any phase_k >= P SHALL be stored as P-1 and SHALL set cfg_err.
REQ-020 In ARM, start SHALL move to RUN, clear the counter to 0 and leave cfg_err unchanged.
REQ-021 In ARM, stop SHALL return to IDLE; if start and stop arrive together, stop wins.
REQ-022 In RUN, counter cnt SHALL step 0,1,..,P-1 and wrap to 0.
REQ-023 Distance d_k SHALL equal (cnt - phase_k) mod P, computed without a divider: cnt-phase_k if cnt>=phase_k, else cnt+P-phase_k.
REQ-024 clk_out[k] SHALL be registered as (d_k < H) while in RUN, giving one cycle of latency from cnt.
REQ-025 tick[k] SHALL be registered high for one cycle when clk_out[k] goes 0->1.
REQ-026 In RUN, stop SHALL go to IDLE, and on the next edge clk_out, tick and running SHALL be 0.
REQ-027 start received in IDLE or RUN SHALL be ignored.
REQ-028 cfg_valid received outside IDLE SHALL be ignored; the latched configuration SHALL stay unchanged.
REQ-029 cfg_err SHALL clear only on reset or on a later accepted configuration that is fully in range.
REQ-030 With H=1, every channel SHALL toggle every cycle; phase 1 SHALL give the inverse of phase 0.

Reset
REQ-031 rst SHALL force IDLE, cnt=0 and latched H=1, and clear all phases.
REQ-032 rst SHALL drive clk_out=0, tick=0, running=0 and cfg_err=0 on the next edge, including when asserted mid-RUN.
REQ-033 After rst, cfg_ready SHALL be high from the first cycle with rst low.

Structure
REQ-034 Package phased_clk_pkg SHALL hold the state enum {IDLE, ARM, RUN} and the DIV_W default constant.
REQ-035 A sub-module phase_chan SHALL be instantiated NCH times, generated in a loop.
REQ-036 Each phase_chan SHALL contain the modular compare, the clk_out register and the tick register, and take cnt, P, H and phase_k as inputs.
REQ-037 The top level SHALL hold the FSM, the configuration registers and the shared counter.

Verification
REQ-038 Scenario "basic phases": NCH=4, H=3, phases {0,1,2,3}, start at cycle T. Required: clk_out[0] high on T+2..T+4 and low on T+5..T+7. Each channel k lags channel 0 by k cycles. Period is 6. tick[0] pulses at T+2 and T+8.
REQ-039 Scenario "invalid config": H=0 accepted. Required: cfg_err=1 and every channel toggles every cycle. Then phase_0=9 with H=2. Required: phase stored as 3 and cfg_err remains 1.
REQ-040 Scenario "stop and restart": stop in RUN at cycle S. Required: clk_out=0 and running=0 at S+1, and cfg_ready=1. Reconfigure and start again. Required: the same phase relation as the first run.
REQ-041 Scenario "simultaneous events": start and stop in the same cycle in ARM. Required: state returns to IDLE and clk_out stays 0. cfg_valid during RUN. Required: cfg_ready=0 and the configuration is unchanged.
REQ-042 Scenario "reset mid-operation": rst asserted for 1 cycle during RUN with H=5. Required: all outputs 0 on the next edge, state IDLE, cfg_err=0.
REQ-043 Scenario "wrap-around": H=2^(DIV_W-1)-1 and phase=P-1. Required: no counter overflow, and channel 0 and the channel with phase=P-1 are offset by exactly P-1 cycles.
